grad_mag_bin: RTL and testbench
===============================

Name: grad_mag_bin

Overview:
- Stage directly downstream of the squared-gradient stage in the HOG front end.
- Consumes the squared gradient magnitude and the signed vertical/horizontal differences. Produces the integer gradient magnitude, floor(sqrt), and the unsigned-orientation bin, 9 bins of 20° over 0–180°.
- Fully pipelined, one sample per clock, valid-only streaming with no backpressure. Output feeds the cell histogram accumulator.

Parameters:
- PIX_W, 8, pixel width; diffs are PIX_W+1 bits signed, mag_sq is 2*PIX_W+1 bits.
- DIFF_LAG, 2, cycles by which ver_diff/hor_diff lead the matching mag_sq at the inputs. Internal delay line depth; 0 is legal.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  mag_sq holds a valid sample this cycle.
- mag_sq  in  2*PIX_W+1  unsigned ver²+hor².
- ver_diff  in  PIX_W+1 signed  bot−top, valid DIFF_LAG cycles before its mag_sq.
- hor_diff  in  PIX_W+1 signed  right−left, same timing as ver_diff.
- out_valid  out  1  mag/bin valid.
- mag  out  PIX_W+1  floor(sqrt(mag_sq)).
- bin  out  4  orientation bin 0..8.

Behaviour:
- Reset: clk/rst only; rst=1 at a posedge clears the whole valid pipeline and sets out_valid=0, mag=0, bin=0 on the next cycle. Data registers other than outputs need no reset.
- Diff alignment: ver_diff/hor_diff pass through a DIFF_LAG-deep register line, no enable. The diffs sampled at cycle t−DIFF_LAG pair with the mag_sq sampled at cycle t when in_valid=1.
- Latency: L = PIX_W+2 cycles, 10 by default. A sample accepted at posedge t appears with out_valid=1 after posedge t+L.
- Pipeline: PIX_W+1 sqrt stages, one root bit per stage, MSB first, plus one output register stage.
- Sqrt result must be exact floor(sqrt) for every input, 0..2^(2*PIX_W+1)−1. Max 9-bit case: 130050 → 360.
- Bin logic: computed from the aligned diffs in the first stage, then carried alongside the sqrt pipeline.
- Throughput: one sample per cycle. Gaps in in_valid propagate as out_valid=0 exactly L cycles later.
- While out_valid=0, mag and bin hold their last values.
- Orientation fold: v=ver, h=hor, aligned.
  - If v<0, or (v=0 and h<0): v=−v, h=−h. This maps the angle to [0°,180°); exactly 180° maps to 0°.
  - Then av=v, ah=|h|, and compare av*256 against T*ah in a 21-bit unsigned compare.
  - Thresholds T = 93, 215, 443, 1452 (tan 20/40/60/80° ×256).
- h≥0 after fold: av*256 < 93·ah → 0; < 215·ah → 1; < 443·ah → 2; < 1452·ah → 3; else 4.
- h<0 after fold: av*256 < 93·ah → 8; < 215·ah → 7; < 443·ah → 6; < 1452·ah → 5; else 4.
- Boundary cases:
  - v=h=0 → bin 0, mag 0.
  - h=0, v≠0 → bin 4.
  - Equality with a threshold selects the higher-angle bin (strict <).
  - Diffs of −2^PIX_W are not produced upstream; behaviour for them is undefined.
- Reset mid-stream: all in-flight samples are dropped, none emitted. The first post-reset sample emerges L cycles after its in_valid. The diff delay line may hold stale data; the upstream restarts after reset anyway.

Test Plan:
- Single sample, ver=10, hor=10, mag_sq=200 (diffs DIFF_LAG cycles earlier) -> exactly 10 cycles later out_valid=1 for 1 cycle, mag=14, bin=2.
- Quadrant/fold cases -> required responses:
  - (ver,hor)=(10,−10) → bin 6.
  - (−10,10) → bin 6.
  - (0,−5) → bin 0.
  - (7,0) → bin 4.
  - (0,0) → bin 0, mag 0.
- Sqrt sweep: mag_sq = 0, 1, 2, 3, 4, 129600, 130049, 130050, 131071 -> mag = 0, 1, 1, 1, 2, 360, 360, 360, 362.
- Back-to-back 64-sample stream with random in_valid gaps -> out_valid pattern equals the input pattern delayed 10 cycles; every mag/bin matches a reference model.
- Threshold edges: hor=256 style exact-equality pairs, e.g. av*256 = 443·ah with ver=443, hor=256 (scaled within range) -> strict-< selects bin 3.
- Assert rst for 1 cycle with 5 samples in flight -> out_valid=0, mag=0, bin=0 the next cycle, no stale outputs. A new sample after reset emerges 10 cycles later.

Source files
------------

// File: rtl/grad_mag_bin.sv
// grad_mag_bin: integer gradient magnitude (floor(sqrt(mag_sq))) and unsigned
// orientation bin (9 bins of 20 degrees over 0..180) for the HOG front end.
// Fully pipelined, one sample per clock. A sample valid in cycle c appears on
// the outputs in cycle c + PIX_W + 2 (PIX_W+1 sqrt stages + output register).
module grad_mag_bin #(
  parameter int PIX_W    = 8,
  parameter int DIFF_LAG = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [2*PIX_W:0]        mag_sq,
  input  logic signed [PIX_W:0]   ver_diff,
  input  logic signed [PIX_W:0]   hor_diff,
  output logic                    out_valid,
  output logic [PIX_W:0]          mag,
  output logic [3:0]              bin
);

  localparam int SQ_W  = 2*PIX_W + 1;
  localparam int RT_W  = PIX_W + 1;
  localparam int NSTG  = PIX_W + 1;
  localparam int TW    = 2*PIX_W + 3;
  localparam int CMP_W = 21;

  // tan(20/40/60/80 deg) scaled by 256
  localparam logic [CMP_W-1:0] T20 = 21'd93;
  localparam logic [CMP_W-1:0] T40 = 21'd215;
  localparam logic [CMP_W-1:0] T60 = 21'd443;
  localparam logic [CMP_W-1:0] T80 = 21'd1452;

  logic signed [PIX_W:0] ver_al, hor_al;

  if (DIFF_LAG == 0) begin : g_nolag
    assign ver_al = ver_diff;
    assign hor_al = hor_diff;
  end else begin : g_lag
    logic signed [PIX_W:0] ver_dl [DIFF_LAG];
    logic signed [PIX_W:0] hor_dl [DIFF_LAG];

    // free-running delay line lining the diffs up with their mag_sq
    always_ff @(posedge clk) begin
      ver_dl[0] <= ver_diff;
      hor_dl[0] <= hor_diff;
      for (int i = 1; i < DIFF_LAG; i++) begin
        ver_dl[i] <= ver_dl[i-1];
        hor_dl[i] <= hor_dl[i-1];
      end
    end

    assign ver_al = ver_dl[DIFF_LAG-1];
    assign hor_al = hor_dl[DIFF_LAG-1];
  end

  logic                    fold, h_neg, is_zero;
  logic signed [PIX_W+1:0] ve, he, vf, hf, hf_abs;
  logic [CMP_W-1:0]        av_s, ah_w;
  logic [3:0]              lvl, bin_c;

  // fold the angle into [0,180) and pick the bin by tangent-threshold compares
  always_comb begin
    ve      = ver_al;
    he      = hor_al;
    fold    = (ve < 0) || ((ve == 0) && (he < 0));
    vf      = fold ? -ve : ve;
    hf      = fold ? -he : he;
    h_neg   = hf < 0;
    hf_abs  = h_neg ? -hf : hf;
    is_zero = (ve == 0) && (he == 0);
    av_s    = CMP_W'($unsigned(vf)) << 8;
    ah_w    = CMP_W'($unsigned(hf_abs));
    if (av_s < ah_w * T20)      lvl = 4'd0;
    else if (av_s < ah_w * T40) lvl = 4'd1;
    else if (av_s < ah_w * T60) lvl = 4'd2;
    else if (av_s < ah_w * T80) lvl = 4'd3;
    else                        lvl = 4'd4;
    if (is_zero)    bin_c = 4'd0;
    else if (h_neg) bin_c = 4'd8 - lvl;
    else            bin_c = lvl;
  end

  logic [NSTG-1:0]  vld_q;
  logic [SQ_W-1:0]  rem_q   [NSTG-1];
  logic [RT_W-1:0]  root_q  [NSTG];
  logic [3:0]       bin_q   [NSTG];
  logic [SQ_W-1:0]  rem_in  [NSTG];
  logic [RT_W-1:0]  root_in [NSTG];
  logic [SQ_W-1:0]  rem_nx  [NSTG];
  logic [RT_W-1:0]  root_nx [NSTG];
  logic [TW-1:0]    trial;
  logic             take;

  // digit-by-digit sqrt: stage k decides root bit PIX_W-k, keeping rem = N - root^2
  always_comb begin
    trial = '0;
    take  = 1'b0;
    rem_in[0]  = mag_sq;
    root_in[0] = '0;
    for (int k = 1; k < NSTG; k++) begin
      rem_in[k]  = rem_q[k-1];
      root_in[k] = root_q[k-1];
    end
    for (int k = 0; k < NSTG; k++) begin
      // (root + 2^b)^2 - root^2 = root*2^(b+1) + 2^(2b); the terms never overlap
      trial      = (TW'(root_in[k]) << (PIX_W - k + 1)) | (TW'(1) << (2*(PIX_W - k)));
      take       = TW'(rem_in[k]) >= trial;
      root_nx[k] = root_in[k] | (RT_W'(take) << (PIX_W - k));
      rem_nx[k]  = take ? (rem_in[k] - trial[SQ_W-1:0]) : rem_in[k];
    end
  end

  // pipeline registers; only the valid chain needs reset
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[NSTG-2:0], in_valid};
    bin_q[0] <= bin_c;
    for (int k = 1; k < NSTG; k++) bin_q[k] <= bin_q[k-1];
    for (int k = 0; k < NSTG; k++) root_q[k] <= root_nx[k];
    for (int k = 0; k < NSTG-1; k++) rem_q[k] <= rem_nx[k];
  end

  // output register: holds the last result while no sample is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      mag       <= '0;
      bin       <= '0;
    end else begin
      out_valid <= vld_q[NSTG-1];
      if (vld_q[NSTG-1]) begin
        mag <= root_q[NSTG-1];
        bin <= bin_q[NSTG-1];
      end
    end
  end

endmodule

// File: tb/tb_grad_mag_bin.sv
// Scoreboard bench for grad_mag_bin: expected mag/bin/arrival cycle pushed
// when a sample is driven, popped when out_valid is seen.
module tb_grad_mag_bin;

  localparam int PIX_W    = 8;
  localparam int DIFF_LAG = 2;
  localparam int L        = PIX_W + 2;

  logic                  clk, rst, in_valid, out_valid;
  logic [2*PIX_W:0]      mag_sq;
  logic signed [PIX_W:0] ver_diff, hor_diff;
  logic [PIX_W:0]        mag;
  logic [3:0]            bin;

  grad_mag_bin #(.PIX_W(PIX_W), .DIFF_LAG(DIFF_LAG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mag_sq(mag_sq),
    .ver_diff(ver_diff), .hor_diff(hor_diff),
    .out_valid(out_valid), .mag(mag), .bin(bin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_d = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  typedef struct { logic v; int m; int ver; int hor; } stim_t;
  typedef struct { int due; int mag; int bin; } exp_t;
  stim_t stim[$];
  exp_t  sb[$];
  exp_t  e;
  int    n_chk = 0, n_pass = 0;
  int    last_mag = 0, last_bin = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  function automatic int ref_sqrt(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic int ref_bin(input int ver, input int hor);
    int v, h, ah, sector;
    int thr [4];
    thr = '{93, 215, 443, 1452};
    v = ver; h = hor;
    if (v == 0 && h == 0) return 0;
    if (v < 0 || (v == 0 && h < 0)) begin v = -v; h = -h; end
    ah = (h < 0) ? -h : h;
    sector = 0;
    for (int i = 0; i < 4; i++) if (v * 256 >= thr[i] * ah) sector = i + 1;
    return (h < 0) ? 8 - sector : sector;
  endfunction

  task automatic add(input logic v, input int m, input int ver, input int hor);
    stim.push_back('{v: v, m: m, ver: ver, hor: hor});
  endtask

  task automatic add_vh(input int ver, input int hor);
    add(1'b1, ver*ver + hor*hor, ver, hor);
  endtask

  // drive the queued stimulus; diffs lead their mag_sq by DIFF_LAG cycles
  task automatic run_stim();
    int n = stim.size();
    for (int k = -DIFF_LAG; k < n; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      mag_sq   = (2*PIX_W+1)'($urandom);
      if (k >= 0) begin
        if (stim[k].v) begin
          in_valid = 1'b1;
          mag_sq   = (2*PIX_W+1)'(stim[k].m);
          sb.push_back('{due: cyc + L, mag: ref_sqrt(stim[k].m),
                         bin: ref_bin(stim[k].ver, stim[k].hor)});
        end
      end
      if (k + DIFF_LAG < n) begin
        ver_diff = (PIX_W+1)'(stim[k+DIFF_LAG].ver);
        hor_diff = (PIX_W+1)'(stim[k+DIFF_LAG].hor);
      end else begin
        ver_diff = '0;
        hor_diff = '0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    stim.delete();
  endtask

  // output monitor, sampling mid-cycle
  always @(negedge clk) begin
    if (rst_d) begin
      check("rst_valid", int'(out_valid), 0);
      check("rst_mag", int'(mag), 0);
      check("rst_bin", int'(bin), 0);
      last_mag = 0;
      last_bin = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", int'(out_valid), 0);
      end else begin
        e = sb.pop_front();
        check("latency", cyc, e.due);
        check("mag", int'(mag), e.mag);
        check("bin", int'(bin), e.bin);
      end
      last_mag = int'(mag);
      last_bin = int'(bin);
    end else begin
      check("hold_mag", int'(mag), last_mag);
      check("hold_bin", int'(bin), last_bin);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("missing_valid", int'(out_valid), 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int sq_vals [9];
    int cnt;
    sq_vals = '{0, 1, 2, 3, 4, 129600, 130049, 130050, 131071};
    rst = 1'b1; in_valid = 1'b0; mag_sq = '0; ver_diff = '0; hor_diff = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single sample then quiet, then fold/quadrant cases
    add_vh(10, 10);
    repeat (12) add(1'b0, 0, 0, 0);
    add_vh(10, -10);
    add_vh(-10, 10);
    add_vh(0, -5);
    add_vh(7, 0);
    add_vh(0, 0);
    add_vh(-7, 0);
    add_vh(-255, -255);
    // sqrt sweep with arbitrary diffs
    for (int i = 0; i < 9; i++) add(1'b1, sq_vals[i], 3, 4);
    // near-threshold pairs on both sides of the fold
    add_vh(111, 64);  add_vh(110, 64);
    add_vh(111, -64); add_vh(110, -64);
    add_vh(93, 255);  add_vh(92, 255);
    add_vh(255, 45);  add_vh(255, 44);
    add_vh(43, 118);  add_vh(43, 119);
    add(1'b0, 0, 0, 0);
    run_stim();

    // random stream of 64 samples with gaps
    cnt = 0;
    while (cnt < 64) begin
      if ($urandom_range(0, 3) != 0) begin
        add_vh(int'($urandom_range(0, 510)) - 255, int'($urandom_range(0, 510)) - 255);
        cnt++;
      end else begin
        add(1'b0, 0, int'($urandom_range(0, 510)) - 255, int'($urandom_range(0, 510)) - 255);
      end
    end
    run_stim();
    repeat (L + 2) @(posedge clk);

    // reset with five samples in flight: all dropped
    for (int i = 0; i < 5; i++) add_vh(20 + i, 30 - i);
    run_stim();
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // first sample after reset
    add_vh(-30, 40);
    run_stim();
    repeat (L + 3) @(posedge clk);
    check("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
